// File: rtl/modarith_pkg.sv
// Shared constants and FSM state encoding for the modular add/sub controller.
package modarith_pkg;

    localparam int unsigned OPW_DEFAULT = 1027;
    localparam int unsigned ADDW        = OPW_DEFAULT + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OP1   = 3'd1,
        WAIT1 = 3'd2,
        OP2   = 3'd3,
        WAIT2 = 3'd4,
        FIN   = 3'd5
    } state_t;

endpackage

// File: rtl/mod_addsub_ctrl.sv
// Sequences a shared multi-precision adder to compute (a+b) mod m or (a-b) mod m.
// MODARITH_CONST_TIME_EN: when defined, both adder passes always run (data-independent timing).
module mod_addsub_ctrl
    import modarith_pkg::*;
#(
    parameter int unsigned OPW = OPW_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           subtract,
    input  logic [OPW-1:0] in_a,
    input  logic [OPW-1:0] in_b,
    input  logic [OPW-1:0] in_m,
    output logic [OPW-1:0] result,
    output logic           done,
    output logic           busy,
    output logic           add_start,
    output logic           add_subtract,
    output logic [OPW-1:0] add_in_a,
    output logic [OPW-1:0] add_in_b,
    input  logic [OPW:0]   add_result,
    input  logic           add_done
);

    localparam int unsigned RW = OPW + 1;

`ifdef MODARITH_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    state_t          state;
    logic            sub_q;
    logic            first;
    logic [OPW-1:0]  m_q;
    logic [RW-1:0]   r1;
    logic [RW-1:0]   r2;
    logic [OPW-1:0]  fin_sel_c;
    logic            need_op2_c;

    // Final select: add keeps r1-m unless it borrowed; sub takes r1+m only if r1 borrowed.
    always_comb begin
        fin_sel_c = r1[OPW-1:0];
        if (sub_q) begin
            if (r1[OPW]) fin_sel_c = r2[OPW-1:0];
        end else begin
            if (!r2[OPW]) fin_sel_c = r2[OPW-1:0];
        end
    end

    assign need_op2_c = !sub_q || add_result[OPW] || CONST_TIME;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sub_q        <= 1'b0;
            first        <= 1'b0;
            m_q          <= '0;
            r1           <= '0;
            r2           <= '0;
            result       <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
            add_start    <= 1'b0;
            add_subtract <= 1'b0;
            add_in_a     <= '0;
            add_in_b     <= '0;
        end else begin
            done      <= 1'b0;
            add_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state        <= OP1;
                        busy         <= 1'b1;
                        sub_q        <= subtract;
                        m_q          <= in_m;
                        add_start    <= 1'b1;
                        add_subtract <= subtract;
                        add_in_a     <= in_a;
                        add_in_b     <= in_b;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                OP1: begin
                    state <= WAIT1;
                    first <= 1'b1;
                end
                // First cycle of a wait may still see the previous pass's done level.
                WAIT1: begin
                    if (first) begin
                        first <= 1'b0;
                    end else if (add_done) begin
                        r1 <= add_result;
                        if (need_op2_c) begin
                            state        <= OP2;
                            add_start    <= 1'b1;
                            add_subtract <= ~sub_q;
                            add_in_a     <= add_result[OPW-1:0];
                            add_in_b     <= m_q;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                OP2: begin
                    state <= WAIT2;
                    first <= 1'b1;
                end
                WAIT2: begin
                    if (first) begin
                        first <= 1'b0;
                    end else if (add_done) begin
                        r2    <= add_result;
                        state <= FIN;
                    end
                end
                FIN: begin
                    result <= fin_sel_c;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Directed bench for mod_addsub_ctrl with a 3-cycle mpadder model and a result scoreboard.
module tb_mod_addsub_ctrl;

    localparam int unsigned OPW = 1027;
    localparam int unsigned RW  = OPW + 1;
    localparam int LAT2 = 12;
    localparam int LAT1 = 7;
`ifdef MODARITH_CONST_TIME_EN
    localparam int SUB_NB_STARTS = 2;
    localparam int SUB_NB_LAT    = LAT2;
`else
    localparam int SUB_NB_STARTS = 1;
    localparam int SUB_NB_LAT    = LAT1;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           subtract = 1'b0;
    logic [OPW-1:0] in_a = '0;
    logic [OPW-1:0] in_b = '0;
    logic [OPW-1:0] in_m = '0;
    logic [OPW-1:0] result;
    logic           done;
    logic           busy;
    logic           add_start;
    logic           add_subtract;
    logic [OPW-1:0] add_in_a;
    logic [OPW-1:0] add_in_b;
    logic [RW-1:0]  add_result = '0;
    logic           add_done = 1'b0;

    int n_checks = 0;
    int n_err = 0;
    int total_starts = 0;
    int total_dones = 0;
    logic [OPW-1:0] exp_q[$];

    always #5 clk = ~clk;

    mod_addsub_ctrl #(.OPW(OPW)) dut (
        .clk(clk), .reset(reset), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .result(result), .done(done), .busy(busy),
        .add_start(add_start), .add_subtract(add_subtract),
        .add_in_a(add_in_a), .add_in_b(add_in_b),
        .add_result(add_result), .add_done(add_done)
    );

    // mpadder model: done rises 3 cycles after its start and the old done level lingers one cycle.
    logic [RW-1:0] pend = '0;
    int cnt = 0;
    always @(posedge clk) begin
        if (add_start) begin
            cnt  <= 3;
            pend <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                 : ({1'b0, add_in_a} + {1'b0, add_in_b});
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 3) add_done <= 1'b0;
            if (cnt == 1) begin
                add_done   <= 1'b1;
                add_result <= pend;
            end
        end
    end

    always @(posedge clk) begin
        if (add_start) total_starts <= total_starts + 1;
        if (done) total_dones <= total_dones + 1;
    end

    function automatic logic [OPW-1:0] ref_mod(input bit sub, input logic [OPW-1:0] a,
                                               input logic [OPW-1:0] b, input logic [OPW-1:0] m);
        logic [RW-1:0] s;
        if (sub) begin
            if (a >= b) s = RW'(a) - RW'(b);
            else        s = RW'(a) + RW'(m) - RW'(b);
        end else begin
            s = RW'(a) + RW'(b);
            if (s >= RW'(m)) s = s - RW'(m);
        end
        return s[OPW-1:0];
    endfunction

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        logic [199:0] o_lo;
        logic [199:0] e_lo;
        o_lo = obs[199:0];
        e_lo = exp[199:0];
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (low 200 bits)", tag, o_lo, e_lo);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"}, RW'(done), RW'(0));
        check({tag, "_busy"}, RW'(busy), RW'(0));
        check({tag, "_add_start"}, RW'(add_start), RW'(0));
        check({tag, "_add_sub"}, RW'(add_subtract), RW'(0));
        check({tag, "_result"}, RW'(result), RW'(0));
        check({tag, "_add_in_a"}, RW'(add_in_a), RW'(0));
        check({tag, "_add_in_b"}, RW'(add_in_b), RW'(0));
    endtask

    task automatic run_op(input string tag, input bit sub, input logic [OPW-1:0] a,
                          input logic [OPW-1:0] b, input logic [OPW-1:0] m,
                          input int exp_starts, input int exp_lat, input bit glitch);
        int edges;
        int s0;
        int d0;
        bit seen;
        logic [OPW-1:0] e;
        @(negedge clk);
        start = 1'b1; subtract = sub; in_a = a; in_b = b; in_m = m;
        exp_q.push_back(ref_mod(sub, a, b, m));
        s0 = total_starts;
        d0 = total_dones;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_c1"}, RW'(busy), RW'(1));
        check({tag, "_add_start_c1"}, RW'(add_start), RW'(1));
        check({tag, "_add_in_a_c1"}, RW'(add_in_a), RW'(a));
        check({tag, "_add_sub_c1"}, RW'(add_subtract), RW'(sub));
        edges = 1;
        seen = 1'b0;
        while (!seen && edges < 60) begin
            if (glitch && edges == 3) begin
                start = 1'b1; subtract = ~sub;
                in_a = OPW'(1); in_b = OPW'(2); in_m = OPW'(11);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, RW'(seen), RW'(1));
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_result"}, RW'(result), RW'(e));
            check({tag, "_latency"}, RW'(edges), RW'(exp_lat));
            check({tag, "_adder_starts"}, RW'(total_starts - s0), RW'(exp_starts));
            check({tag, "_busy_at_done"}, RW'(busy), RW'(1));
            @(posedge clk); #1;
            check({tag, "_done_pulse"}, RW'(done), RW'(0));
            check({tag, "_busy_after"}, RW'(busy), RW'(0));
            check({tag, "_result_hold"}, RW'(result), RW'(e));
            if (glitch) begin
                repeat (20) @(posedge clk);
                #1;
                check({tag, "_single_done"}, RW'(total_dones - d0), RW'(1));
            end
        end else begin
            exp_q.delete();
        end
    endtask

    logic [OPW-1:0] big;
    logic [OPW-1:0] rm;
    logic [OPW-1:0] ra;
    logic [OPW-1:0] rb;
    bit             rs;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        run_op("add_7_9", 1'b0, OPW'(7), OPW'(9), OPW'(13), 2, LAT2, 1'b0);
        run_op("add_6_7_eq_m", 1'b0, OPW'(6), OPW'(7), OPW'(13), 2, LAT2, 1'b0);
        run_op("add_2_3", 1'b0, OPW'(2), OPW'(3), OPW'(13), 2, LAT2, 1'b0);
        run_op("sub_3_9", 1'b1, OPW'(3), OPW'(9), OPW'(13), 2, LAT2, 1'b0);
        run_op("sub_9_3", 1'b1, OPW'(9), OPW'(3), OPW'(13), SUB_NB_STARTS, SUB_NB_LAT, 1'b0);
        run_op("add_glitch", 1'b0, OPW'(4), OPW'(5), OPW'(13), 2, LAT2, 1'b1);

        // Reset during WAIT2, with a start asserted alongside the reset.
        @(negedge clk);
        start = 1'b1; subtract = 1'b0; in_a = OPW'(7); in_b = OPW'(9); in_m = OPW'(13);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("wait2_busy", RW'(busy), RW'(1));
        @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("post_reset_add_start", RW'(add_start), RW'(0));
        check("post_reset_busy", RW'(busy), RW'(0));
        run_op("add_1_1", 1'b0, OPW'(1), OPW'(1), OPW'(13), 2, LAT2, 1'b0);

        big = '0;
        big[1025] = 1'b1;
        run_op("full_width", 1'b0, big, big, big + OPW'(1), 2, LAT2, 1'b0);
        check("full_width_value", RW'(result), RW'(big - OPW'(1)));

        for (int i = 0; i < 4; i++) begin
            rm = OPW'($urandom_range(2, 1 << 20));
            ra = OPW'($urandom_range(0, 32'(rm) - 1));
            rb = OPW'($urandom_range(0, 32'(rm) - 1));
            rs = 1'($urandom_range(0, 1));
            if (rs && ra >= rb)
                run_op("rand_sub_nb", 1'b1, ra, rb, rm, SUB_NB_STARTS, SUB_NB_LAT, 1'b0);
            else
                run_op("rand_op", rs, ra, rb, rm, 2, LAT2, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
